rect_layer_renderer: RTL



---
 rtl/rect_layer_renderer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/rect_layer_renderer.sv
// rect_layer_renderer: per-pixel compositor that overlays NUM_RECTS filled
// rectangles on a background colour, with frame-synchronous attribute commit.
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   FRAME_START           one-cycle pulse; commits pending attributes to active
//   PIXEL_X/Y/VALID       pixel coordinate and visible-area qualifier
//   WR_EN/IDX/FIELD/DATA  pending attribute write port
//   COLOR_OUT/VALID       composited colour, 2 cycles after the pixel input
//   COLLISION_FLAGS       per-frame rect0-vs-rect_i overlap flags
//
// Optional feature macro: RECT_COLLISION_EN (adds COLLISION_FLAGS and its
// accumulator; absent by default).
module rect_layer_renderer #(
    parameter int unsigned NUM_RECTS   = 4,
    parameter int unsigned COORD_WIDTH = 11,
    parameter int unsigned COLOR_WIDTH = 8,
    parameter logic [COLOR_WIDTH-1:0] BG_COLOR = COLOR_WIDTH'(8'h00)
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   FRAME_START,
    input  logic [COORD_WIDTH-1:0] PIXEL_X,
    input  logic [COORD_WIDTH-1:0] PIXEL_Y,
    input  logic                   PIXEL_VALID,
    input  logic                   WR_EN,
    input  logic [3:0]             WR_IDX,
    input  logic [2:0]             WR_FIELD,
    input  logic [COORD_WIDTH-1:0] WR_DATA,
    output logic [COLOR_WIDTH-1:0] COLOR_OUT,
    output logic                   COLOR_VALID
`ifdef RECT_COLLISION_EN
    ,
    output logic [NUM_RECTS-1:0]   COLLISION_FLAGS
`endif
);

    // Pending (written by WR_*) and active (rendered) attribute sets
    logic [COORD_WIDTH-1:0] pend_xmin_q [NUM_RECTS], pend_xmin_d [NUM_RECTS];
    logic [COORD_WIDTH-1:0] pend_ymin_q [NUM_RECTS], pend_ymin_d [NUM_RECTS];
    logic [COORD_WIDTH-1:0] pend_xmax_q [NUM_RECTS], pend_xmax_d [NUM_RECTS];
    logic [COORD_WIDTH-1:0] pend_ymax_q [NUM_RECTS], pend_ymax_d [NUM_RECTS];
    logic [COLOR_WIDTH-1:0] pend_color_q[NUM_RECTS], pend_color_d[NUM_RECTS];
    logic [NUM_RECTS-1:0]   pend_en_q, pend_en_d;

    logic [COORD_WIDTH-1:0] act_xmin_q [NUM_RECTS], act_xmin_d [NUM_RECTS];
    logic [COORD_WIDTH-1:0] act_ymin_q [NUM_RECTS], act_ymin_d [NUM_RECTS];
    logic [COORD_WIDTH-1:0] act_xmax_q [NUM_RECTS], act_xmax_d [NUM_RECTS];
    logic [COORD_WIDTH-1:0] act_ymax_q [NUM_RECTS], act_ymax_d [NUM_RECTS];
    logic [COLOR_WIDTH-1:0] act_color_q[NUM_RECTS], act_color_d[NUM_RECTS];
    logic [NUM_RECTS-1:0]   act_en_q, act_en_d;

    // Pipeline
    logic [NUM_RECTS-1:0]   hit_c;
    logic [NUM_RECTS-1:0]   hit_s1_q;
    logic [COLOR_WIDTH-1:0] color_s1_q[NUM_RECTS];
    logic                   valid_s1_q;
    logic [COLOR_WIDTH-1:0] sel_color_c;
    logic [COLOR_WIDTH-1:0] color_out_d, color_out_q;
    logic                   color_valid_q;

    // Pending writes; out-of-range indices simply match no channel
    always_comb begin
        pend_xmin_d  = pend_xmin_q;
        pend_ymin_d  = pend_ymin_q;
        pend_xmax_d  = pend_xmax_q;
        pend_ymax_d  = pend_ymax_q;
        pend_color_d = pend_color_q;
        pend_en_d    = pend_en_q;
        for (int unsigned i = 0; i < NUM_RECTS; i++) begin
            if (WR_EN && (WR_IDX == 4'(i))) begin
                case (WR_FIELD)
                    3'd0:    pend_xmin_d[i]  = WR_DATA;
                    3'd1:    pend_ymin_d[i]  = WR_DATA;
                    3'd2:    pend_xmax_d[i]  = WR_DATA;
                    3'd3:    pend_ymax_d[i]  = WR_DATA;
                    3'd4:    pend_color_d[i] = WR_DATA[COLOR_WIDTH-1:0];
                    3'd5:    pend_en_d[i]    = WR_DATA[0];
                    default: ;
                endcase
            end
        end
    end

    // Frame-start commit; same-cycle writes only reach the pending set
    always_comb begin
        act_xmin_d  = act_xmin_q;
        act_ymin_d  = act_ymin_q;
        act_xmax_d  = act_xmax_q;
        act_ymax_d  = act_ymax_q;
        act_color_d = act_color_q;
        act_en_d    = act_en_q;
        if (FRAME_START) begin
            for (int unsigned i = 0; i < NUM_RECTS; i++) begin
                act_xmin_d[i]  = pend_xmin_q[i];
                act_ymin_d[i]  = pend_ymin_q[i];
                act_xmax_d[i]  = pend_xmax_q[i];
                act_ymax_d[i]  = pend_ymax_q[i];
                act_color_d[i] = pend_color_q[i];
            end
            act_en_d = pend_en_q;
        end
    end

    // Half-open hit test; empty rectangles fail the range check naturally
    always_comb begin
        hit_c = '0;
        for (int unsigned i = 0; i < NUM_RECTS; i++) begin
            hit_c[i] = act_en_q[i]
                    && (PIXEL_X >= act_xmin_q[i]) && (PIXEL_X < act_xmax_q[i])
                    && (PIXEL_Y >= act_ymin_q[i]) && (PIXEL_Y < act_ymax_q[i]);
        end
    end

    // Priority encode: scanning downward lets the lowest hit index win
    always_comb begin
        sel_color_c = BG_COLOR;
        for (int i = int'(NUM_RECTS) - 1; i >= 0; i--) begin
            if (hit_s1_q[i]) sel_color_c = color_s1_q[i];
        end
        color_out_d = valid_s1_q ? sel_color_c : '0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < NUM_RECTS; i++) begin
                pend_xmin_q[i]  <= '0;
                pend_ymin_q[i]  <= '0;
                pend_xmax_q[i]  <= '0;
                pend_ymax_q[i]  <= '0;
                pend_color_q[i] <= '0;
                act_xmin_q[i]   <= '0;
                act_ymin_q[i]   <= '0;
                act_xmax_q[i]   <= '0;
                act_ymax_q[i]   <= '0;
                act_color_q[i]  <= '0;
                color_s1_q[i]   <= '0;
            end
            pend_en_q     <= '0;
            act_en_q      <= '0;
            hit_s1_q      <= '0;
            valid_s1_q    <= 1'b0;
            color_out_q   <= '0;
            color_valid_q <= 1'b0;
        end else begin
            pend_xmin_q   <= pend_xmin_d;
            pend_ymin_q   <= pend_ymin_d;
            pend_xmax_q   <= pend_xmax_d;
            pend_ymax_q   <= pend_ymax_d;
            pend_color_q  <= pend_color_d;
            pend_en_q     <= pend_en_d;
            act_xmin_q    <= act_xmin_d;
            act_ymin_q    <= act_ymin_d;
            act_xmax_q    <= act_xmax_d;
            act_ymax_q    <= act_ymax_d;
            act_color_q   <= act_color_d;
            act_en_q      <= act_en_d;
            // Colours are captured with the hits so in-flight pixels ignore commits
            hit_s1_q      <= hit_c;
            color_s1_q    <= act_color_q;
            valid_s1_q    <= PIXEL_VALID;
            color_out_q   <= color_out_d;
            color_valid_q <= valid_s1_q;
        end
    end

    assign COLOR_OUT   = color_out_q;
    assign COLOR_VALID = color_valid_q;

`ifdef RECT_COLLISION_EN
    logic [NUM_RECTS-1:0] coll_acc_q, coll_acc_d;
    logic [NUM_RECTS-1:0] coll_flags_q, coll_flags_d;

    // Sticky rect0-vs-rect_i overlap; frame start snapshots then restarts
    always_comb begin
        coll_acc_d   = FRAME_START ? '0 : coll_acc_q;
        coll_flags_d = FRAME_START ? coll_acc_q : coll_flags_q;
        for (int unsigned i = 1; i < NUM_RECTS; i++) begin
            if (valid_s1_q && hit_s1_q[0] && hit_s1_q[i]) coll_acc_d[i] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            coll_acc_q   <= '0;
            coll_flags_q <= '0;
        end else begin
            coll_acc_q   <= coll_acc_d;
            coll_flags_q <= coll_flags_d;
        end
    end

    assign COLLISION_FLAGS = coll_flags_q;
`endif

endmodule
